// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, control FSM states.
// Ports: none (package). Helper is_exc() classifies terminal status codes.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] AOK = 4'h1;
  localparam logic [3:0] HLT = 4'h2;
  localparam logic [3:0] ADR = 4'h3;
  localparam logic [3:0] INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_e;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == HLT) || (s == ADR) || (s == INS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline registers and pipe_ctrl: stage fields in,
// stall/bubble/set_cc controls out. master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic [3:0] D_icode;
  logic [3:0] E_icode;
  logic [3:0] M_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [3:0] m_stat;
  logic [3:0] W_stat;
  logic [3:0] W_icode;

  logic F_stall;
  logic D_stall;
  logic D_bubble;
  logic E_stall;
  logic E_bubble;
  logic M_stall;
  logic M_bubble;
  logic W_stall;
  logic set_cc;

  modport master (
    output D_icode, E_icode, M_icode,
    output d_srcA, d_srcB, E_dstM, e_Cnd,
    output m_stat, W_stat, W_icode,
    input  F_stall, D_stall, D_bubble,
    input  E_stall, E_bubble, M_stall,
    input  M_bubble, W_stall, set_cc
  );

  modport slave (
    input  D_icode, E_icode, M_icode,
    input  d_srcA, d_srcB, E_dstM, e_Cnd,
    input  m_stat, W_stat, W_icode,
    output F_stall, D_stall, D_bubble,
    output E_stall, E_bubble, M_stall,
    output M_bubble, W_stall, set_cc
  );
endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms: load-use, mispredict, ret in flight, exceptions.
// In: stage icodes, decode sources, E_dstM, e_Cnd, m/W status. Out: lu mp rt exc_m exc_w.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       lu,
  output logic       mp,
  output logic       rt,
  output logic       exc_m,
  output logic       exc_w
);

  logic e_load;
  logic dst_hit;

  assign e_load  = (E_icode == MRMOVQ)
                || (E_icode == POPQ);
  assign dst_hit = (E_dstM == d_srcA)
                || (E_dstM == d_srcB);
  assign lu = e_load && (E_dstM != RNONE)
           && dst_hit;

  assign mp = (E_icode == JXX) && !e_Cnd;

  assign rt = (D_icode == RET)
           || (E_icode == RET)
           || (M_icode == RET);

  assign exc_m = is_exc(m_stat);
  assign exc_w = is_exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble strobes, CC gating, run/halt/fault FSM, perf counters.
// Ports: clk, reset, run, pl (pipe_ctrl_if.slave), cpu_stat, five CNT_W counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  pipe_ctrl_if.slave       pl,
  output logic [3:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] rt_cnt
);

  logic lu, mp, rt, exc_m, exc_w;

  pipe_hazard_detect u_hz (
    .D_icode (pl.D_icode),
    .E_icode (pl.E_icode),
    .M_icode (pl.M_icode),
    .d_srcA  (pl.d_srcA),
    .d_srcB  (pl.d_srcB),
    .E_dstM  (pl.E_dstM),
    .e_Cnd   (pl.e_Cnd),
    .m_stat  (pl.m_stat),
    .W_stat  (pl.W_stat),
    .lu      (lu),
    .mp      (mp),
    .rt      (rt),
    .exc_m   (exc_m),
    .exc_w   (exc_w)
  );

  state_e     state_q, state_d;
  logic [3:0] fstat_q, fstat_d;
  logic       frozen;
  logic       rt_bub;
  logic       retire;

  assign frozen = (state_q != RUN) || !run;
  // ret bubble only counts when load-use is not holding D instead
  assign rt_bub = rt && !lu;
  assign retire = (pl.W_stat == AOK)
               && (pl.W_icode != NOP)
               && (pl.W_icode != HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      fstat_q <= AOK;
    end else begin
      state_q <= state_d;
      fstat_q <= fstat_d;
    end
  end

  // unknown non-AOK codes fault as INS
  always_comb begin
    state_d = state_q;
    fstat_d = fstat_q;
    if (state_q == RUN && pl.W_stat != AOK) begin
      if (pl.W_stat == HLT) begin
        state_d = HALTED;
      end else begin
        state_d = FAULT;
        fstat_d = (pl.W_stat == ADR) ? ADR : INS;
      end
    end
  end

  logic f_stall, d_stall, d_bubble;
  logic e_stall, e_bubble;
  logic m_stall, m_bubble;
  logic w_stall, cc_en;

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_stall  = 1'b0;
    e_bubble = 1'b0;
    m_stall  = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    cc_en    = 1'b0;
    if (reset) begin
      f_stall = 1'b0;
    end else if (frozen) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      m_stall = 1'b1;
      w_stall = 1'b1;
    end else begin
      f_stall  = lu || rt;
      // mispredict squash beats load-use hold
      d_stall  = lu && !mp;
      d_bubble = mp || rt_bub;
      e_bubble = mp || lu;
      m_bubble = exc_m || exc_w;
      w_stall  = exc_w;
      cc_en    = (pl.E_icode == OPQ)
              && !exc_m && !exc_w;
    end
  end

  assign pl.F_stall  = f_stall;
  assign pl.D_stall  = d_stall;
  assign pl.D_bubble = d_bubble;
  assign pl.E_stall  = e_stall;
  assign pl.E_bubble = e_bubble;
  assign pl.M_stall  = m_stall;
  assign pl.M_bubble = m_bubble;
  assign pl.W_stall  = w_stall;
  assign pl.set_cc   = cc_en;

  always_comb begin
    cpu_stat = AOK;
    unique case (state_q)
      RUN:     cpu_stat = AOK;
      HALTED:  cpu_stat = HLT;
      FAULT:   cpu_stat = fstat_q;
      default: cpu_stat = AOK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
      lu_cnt  <= '0;
      mp_cnt  <= '0;
      rt_cnt  <= '0;
    end else if (!frozen) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      ret_cnt <= ret_cnt + CNT_W'(retire);
      lu_cnt  <= lu_cnt + CNT_W'(lu);
      mp_cnt  <= mp_cnt + CNT_W'(mp);
      rt_cnt  <= rt_cnt + CNT_W'(rt_bub);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, monitor compares.
// Directed hazard/halt/fault/wrap cases followed by randomized blocks.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMOD  = 16;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic [3:0] cpu_stat;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;
  logic [CNT_W-1:0] lu_cnt, mp_cnt, rt_cnt;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pl       (pif),
    .cpu_stat (cpu_stat),
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt),
    .lu_cnt   (lu_cnt),
    .mp_cnt   (mp_cnt),
    .rt_cnt   (rt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       run;
    bit [3:0] di, ei, mi;
    bit [3:0] sa, sb, dm;
    bit       cnd;
    bit [3:0] ms, ws, wi;
  } stim_t;

  typedef struct {
    int        idx;
    bit [8:0]  ctrl;
    bit [3:0]  stat;
    bit [19:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;

  // reference machine: 0 running, 1 halted, 2 faulted
  int m_mode = 0;
  int m_fstat = 1;
  int c_cyc = 0, c_ret = 0, c_lu = 0;
  int c_mp = 0, c_rt = 0;

  function automatic bit in_exc(bit [3:0] s);
    return s == 2 || s == 3 || s == 4;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s.rst = 0; s.run = 1;
    s.di = NOP; s.ei = NOP; s.mi = NOP;
    s.sa = RNONE; s.sb = RNONE; s.dm = RNONE;
    s.cnd = 1;
    s.ms = AOK; s.ws = AOK; s.wi = NOP;
    return s;
  endfunction

  function automatic stim_t rnd(bit term);
    stim_t s;
    s = base();
    s.run = ($urandom_range(0, 7) != 0);
    s.di = 4'($urandom_range(0, 11));
    case ($urandom_range(0, 5))
      0: s.ei = 4'h5;
      1: s.ei = 4'hB;
      2: s.ei = 4'h7;
      3: s.ei = 4'h6;
      default: s.ei = 4'($urandom_range(0, 11));
    endcase
    s.mi = 4'($urandom_range(0, 11));
    s.sa = 4'($urandom_range(0, 15));
    s.sb = 4'($urandom_range(0, 15));
    s.dm = ($urandom_range(0, 2) == 0)
         ? s.sb : 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) s.dm = s.sa;
    s.cnd = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 5) == 0)
      s.ms = 4'($urandom_range(0, 7));
    if (term && $urandom_range(0, 29) == 0)
      s.ws = 4'($urandom_range(0, 7));
    s.wi = 4'($urandom_range(0, 11));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lu, mp, rt, em, ew, fz;
    bit fs, ds, db, es, eb, ms_, mb, wsl, cc;
    @(posedge clk);
    #1;
    reset = s.rst;
    run = s.run;
    pif.D_icode = s.di;
    pif.E_icode = s.ei;
    pif.M_icode = s.mi;
    pif.d_srcA = s.sa;
    pif.d_srcB = s.sb;
    pif.E_dstM = s.dm;
    pif.e_Cnd = s.cnd;
    pif.m_stat = s.ms;
    pif.W_stat = s.ws;
    pif.W_icode = s.wi;

    lu = (s.ei == 5 || s.ei == 11) && s.dm != 15
      && (s.dm == s.sa || s.dm == s.sb);
    mp = (s.ei == 7) && !s.cnd;
    rt = (s.di == 9) || (s.ei == 9) || (s.mi == 9);
    em = in_exc(s.ms);
    ew = in_exc(s.ws);
    if (s.rst) begin
      m_mode = 0;
      c_cyc = 0; c_ret = 0; c_lu = 0;
      c_mp = 0; c_rt = 0;
    end
    fz = (m_mode != 0) || !s.run;
    {fs, ds, db, es, eb, ms_, mb, wsl, cc} = '0;
    if (s.rst) begin
      fs = 0;
    end else if (fz) begin
      {fs, ds, es, ms_, wsl} = 5'b11111;
    end else begin
      fs = lu || rt;
      ds = lu && !mp;
      db = mp || (rt && !lu);
      eb = mp || lu;
      mb = em || ew;
      wsl = ew;
      cc = (s.ei == 6) && !em && !ew;
    end
    e.idx = pushed;
    e.ctrl = {fs, ds, db, es, eb, ms_, mb, wsl, cc};
    e.stat = (m_mode == 0) ? 4'd1
           : (m_mode == 1) ? 4'd2 : 4'(m_fstat);
    e.cnt = {4'(c_cyc), 4'(c_ret), 4'(c_lu),
             4'(c_mp), 4'(c_rt)};
    sb_q.push_back(e);
    pushed++;

    if (!s.rst) begin
      if (!fz) begin
        c_cyc = (c_cyc + 1) % CMOD;
        if (s.ws == 1 && s.wi != 0 && s.wi != 1)
          c_ret = (c_ret + 1) % CMOD;
        if (lu) c_lu = (c_lu + 1) % CMOD;
        if (mp) c_mp = (c_mp + 1) % CMOD;
        if (rt && !lu) c_rt = (c_rt + 1) % CMOD;
      end
      if (m_mode == 0 && s.ws != 1) begin
        if (s.ws == 2) begin
          m_mode = 1;
        end else begin
          m_mode = 2;
          m_fstat = (s.ws == 3) ? 3 : 4;
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    bit [8:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        popped++;
        act = {pif.F_stall, pif.D_stall, pif.D_bubble,
               pif.E_stall, pif.E_bubble, pif.M_stall,
               pif.M_bubble, pif.W_stall, pif.set_cc};
        total++;
        if (act !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl#%0d got %b want %b",
                   e.idx, act, e.ctrl);
        end
        total++;
        if (cpu_stat !== e.stat) begin
          bad++;
          $display("FAIL cpu_stat#%0d got %0d want %0d",
                   e.idx, cpu_stat, e.stat);
        end
        total++;
        if ({cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rt_cnt}
            !== e.cnt) begin
          bad++;
          $display("FAIL cnts#%0d got %h want %h", e.idx,
                   {cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rt_cnt},
                   e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    run = 1'b1;
    s = base();
    pif.D_icode = s.di; pif.E_icode = s.ei;
    pif.M_icode = s.mi; pif.d_srcA = s.sa;
    pif.d_srcB = s.sb; pif.E_dstM = s.dm;
    pif.e_Cnd = s.cnd; pif.m_stat = s.ms;
    pif.W_stat = s.ws; pif.W_icode = s.wi;

    s = base(); s.rst = 1;
    apply(s); apply(s);

    // load-use
    s = base(); s.ei = MRMOVQ; s.dm = 4'd3; s.sa = 4'd3;
    apply(s);
    apply(base());
    // mispredict
    s = base(); s.ei = JXX; s.cnd = 0;
    apply(s);
    // ret in flight three cycles
    s = base(); s.di = RET;
    repeat (3) apply(s);
    // ret and load-use together
    s = base(); s.di = RET; s.ei = POPQ;
    s.dm = 4'd4; s.sb = 4'd4;
    apply(s);
    // retirements and CC gating
    s = base(); s.wi = OPQ; s.ei = OPQ;
    repeat (2) apply(s);
    s.ms = ADR;
    apply(s);
    // run drop while load-use pending
    s = base(); s.ei = MRMOVQ; s.dm = 4'd2; s.sa = 4'd2;
    s.run = 0;
    repeat (2) apply(s);
    s.run = 1;
    apply(s);
    // wrap: 16 unfrozen cycles, then 5 frozen
    repeat (16) apply(base());
    s = base(); s.run = 0;
    repeat (5) apply(s);
    apply(base());
    // halt
    s = base(); s.ws = HLT;
    apply(s);
    s = base(); s.ei = JXX; s.cnd = 0; s.di = RET;
    repeat (3) apply(s);
    s = base(); s.rst = 1;
    apply(s);
    // fault via ADR, async reset while faulted
    s = base(); s.ms = ADR; s.ei = OPQ;
    apply(s);
    s = base(); s.ws = ADR;
    apply(s);
    repeat (3) apply(base());
    s = base(); s.rst = 1;
    apply(s);
    apply(base());
    // unknown non-AOK W status
    s = base(); s.ws = 4'd7;
    apply(s);
    repeat (2) apply(base());
    s = base(); s.rst = 1;
    apply(s);

    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 60; i++) apply(rnd(1'b1));
      s = base(); s.rst = 1;
      apply(s);
    end
    for (int i = 0; i < 80; i++) apply(rnd(1'b0));

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0 || popped != pushed) begin
      bad++;
      $display("FAIL drain got popped=%0d want %0d",
               popped, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
